parity_rx: RTL and testbench
============================

PARITY_RX -- requirements
Module: parity_rx

Interface
REQ-001 Parameter: DATA_W, default 8, number of data bits per frame (1..16).
REQ-002 Parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit (even, >= 4).
REQ-003 Parameter: PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: rx_in  input  1  serial line, idle high, asynchronous to clk.
REQ-007 Port: data_out  output  DATA_W  last received data word.
REQ-008 Port: data_valid  output  1  one-cycle pulse, new frame complete.
REQ-009 Port: parity_err  output  1  parity check result of last frame.
REQ-010 Port: frame_err  output  1  stop-bit check result of last frame.
REQ-011 Port: busy  output  1  high while a frame is in progress (state != IDLE).

Function
REQ-012 Frame format SHALL be: 1 start bit (0), DATA_W data bits LSB first, 1 parity bit, 1 stop bit (1).
REQ-013 rx_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE -> START on rx_s == 0; bit-cycle counter cleared.
REQ-016 In START, rx_s SHALL be sampled CLKS_PER_BIT/2 cycles after entry; if 1 (glitch), -> IDLE with no outputs changed; if 0, -> DATA.
REQ-017 In DATA, a bit SHALL be sampled every CLKS_PER_BIT cycles and shifted into bit position 0..DATA_W-1 in order; -> PARITY after bit DATA_W-1.
REQ-018 A running XOR SHALL accumulate every sampled data bit plus the parity bit.
REQ-019 In PARITY, one bit SHALL be sampled CLKS_PER_BIT cycles after the last data sample; -> STOP.
REQ-020 In STOP, rx_s SHALL be sampled CLKS_PER_BIT cycles after the parity sample; -> IDLE.
REQ-021 On the cycle after the stop sample: data_valid = 1 for exactly one cycle, data_out = shifted word, parity_err = (XOR != PARITY_ODD), frame_err = (stop sample == 0).
REQ-022 data_out, parity_err, frame_err SHALL hold until the next data_valid; frames with errors SHALL still be delivered.
REQ-023 A new start bit SHALL be accepted the cycle after return to IDLE (back-to-back frames, no gap required).
REQ-024 If stop sample == 0, the FSM SHALL still return to IDLE and re-arm on rx_s == 0.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, counters 0, synchronizer flops 1, shift register 0.
REQ-026 Reset values: data_out 0, data_valid 0, parity_err 0, frame_err 0, busy 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no data_valid pulse.

Structure
REQ-028 FSM state enum and frame-field constants SHALL live in shared package parity_rx_pkg.
REQ-029 Synchronizer SHALL be sub-module sync_2ff (1-bit, reset value 1).

Verification
REQ-030 Frame data 0xA5, parity 0, stop 1 (defaults) -> one data_valid pulse, data_out 0xA5, parity_err 0, frame_err 0.
REQ-031 Frame data 0xA5, parity 1 -> data_out 0xA5, parity_err 1, frame_err 0; with PARITY_ODD=1 same frame -> parity_err 0.
REQ-032 Frame data 0x3C, parity 0, stop 0 -> frame_err 1, parity_err 0, FSM back to IDLE, next frame 0x01 (parity 1) received correctly.
REQ-033 rx_in low for 1 clk then high -> no data_valid, busy returns 0 within CLKS_PER_BIT/2 + 3 cycles.
REQ-034 Back-to-back frames 0x55 then 0xFF with no idle gap -> two data_valid pulses, data_out 0x55 then 0xFF, no errors.
REQ-035 rst_n asserted during data bit 4 of a frame -> all outputs 0 immediately, no data_valid; subsequent 0x81 frame received correctly.

Source files
------------

// File: rtl/parity_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : parity_rx_pkg
// Purpose  : Shared FSM state encodings and frame-field levels for parity_rx.
// Revision : 1.0
// ============================================================================
package parity_rx_pkg;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    localparam logic c_START_BIT  = 1'b0;
    localparam logic c_STOP_BIT   = 1'b1;
    localparam logic c_LINE_IDLE  = 1'b1;

endpackage : parity_rx_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for a single asynchronous bit.
// Revision : 1.0
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : parity_rx
// Purpose  : Serial receiver: start, DATA_W bits LSB first, parity, stop.
// Revision : 1.0
// ============================================================================
module parity_rx
    import parity_rx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_W - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic               c_ODD      = (PARITY_ODD != 0);

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_bit_idx;
    logic [DATA_W-1:0]  r_shift;
    logic               r_xor;
    logic               w_rx_s;
    logic [DATA_W-1:0]  w_shift_next;

    sync_2ff #(
        .RST_VAL (c_LINE_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (rx_in),
        .o_q   (w_rx_s)
    );

    // Right shift: the first (LSB) bit lands in position 0 after DATA_W samples.
    generate
        if (DATA_W > 1) begin : g_shift_wide
            assign w_shift_next = {w_rx_s, r_shift[DATA_W-1:1]};
        end else begin : g_shift_one
            assign w_shift_next = w_rx_s;
        end
    endgenerate

    assign busy = (r_state != c_ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_xor      <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_rx_s == c_START_BIT) begin
                        r_state <= c_ST_START;
                        r_cnt   <= '0;
                    end
                end
                c_ST_START: begin
                    if (r_cnt == c_CNT_HALF) begin
                        r_cnt <= '0;
                        if (w_rx_s == c_START_BIT) begin
                            r_state   <= c_ST_DATA;
                            r_bit_idx <= '0;
                            r_xor     <= 1'b0;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_DATA: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= w_shift_next;
                        r_xor   <= r_xor ^ w_rx_s;
                        if (r_bit_idx == c_IDX_LAST) begin
                            r_state <= c_ST_PARITY;
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_PARITY: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_xor   <= r_xor ^ w_rx_s;
                        r_state <= c_ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_STOP: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt      <= '0;
                        r_state    <= c_ST_IDLE;
                        data_valid <= 1'b1;
                        data_out   <= r_shift;
                        parity_err <= (r_xor != c_ODD);
                        frame_err  <= (w_rx_s != c_STOP_BIT);
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule : parity_rx
`default_nettype wire

// File: tb/tb_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_rx
// Purpose  : Directed self-checking bench for parity_rx (even and odd parity).
// Revision : 1.0
// ============================================================================
module tb_parity_rx;

    localparam int c_DW   = 8;
    localparam int c_CPB  = 4;
    localparam int c_HALF = c_CPB / 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            rx_in;
    logic [c_DW-1:0] data_out, data_out_o;
    logic            data_valid, data_valid_o;
    logic            parity_err, parity_err_o;
    logic            frame_err, frame_err_o;
    logic            busy, busy_o;

    int tests = 0;
    int fails = 0;

    // {parity_err, frame_err, data_out} per data_valid pulse
    logic [c_DW+1:0] q_even[$];
    logic            q_odd_perr[$];
    bit              seen_busy;

    always #5 clk = ~clk;

    parity_rx #(.DATA_W(c_DW), .CLKS_PER_BIT(c_CPB), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .data_out(data_out),
        .data_valid(data_valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    parity_rx #(.DATA_W(c_DW), .CLKS_PER_BIT(c_CPB), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .data_out(data_out_o),
        .data_valid(data_valid_o), .parity_err(parity_err_o),
        .frame_err(frame_err_o), .busy(busy_o)
    );

    always @(negedge clk) begin
        if (data_valid)   q_even.push_back({parity_err, frame_err, data_out});
        if (data_valid_o) q_odd_perr.push_back(parity_err_o);
        if (busy)         seen_busy = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (c_CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [c_DW-1:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < c_DW; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_one(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        check({tag, "_count"}, q_even.size(), 1);
        if (q_even.size() >= 1) begin
            check({tag, "_data"}, q_even[0][c_DW-1:0], d);
            check({tag, "_perr"}, q_even[0][c_DW+1], pe);
            check({tag, "_ferr"}, q_even[0][c_DW], fe);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_valid", data_valid, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(4);

        // 0xA5 with even parity bit 0
        q_even.delete(); q_odd_perr.delete();
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(4);
        check_one("a5_p0", 8'hA5, 1'b0, 1'b0);
        check("a5_p0_odd_count", q_odd_perr.size(), 1);
        if (q_odd_perr.size() >= 1) check("a5_p0_odd_perr", q_odd_perr[0], 1);
        check("a5_p0_busy", busy, 0);

        // 0xA5 with parity bit 1: bad for even, good for odd
        q_even.delete(); q_odd_perr.delete();
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(4);
        check_one("a5_p1", 8'hA5, 1'b1, 1'b0);
        check("a5_p1_odd_count", q_odd_perr.size(), 1);
        if (q_odd_perr.size() >= 1) check("a5_p1_odd_perr", q_odd_perr[0], 0);
        check("a5_p1_hold_perr", parity_err, 1);

        // Bad stop bit, then recovery
        q_even.delete();
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(8);
        check_one("3c_stop0", 8'h3C, 1'b0, 1'b1);
        check("3c_stop0_busy", busy, 0);
        q_even.delete();
        send_frame(8'h01, 1'b1, 1'b1);
        idle(4);
        check_one("01_after", 8'h01, 1'b0, 1'b0);

        // One-cycle glitch on an idle line
        q_even.delete();
        seen_busy = 1'b0;
        rx_in = 1'b0;
        @(negedge clk);
        rx_in = 1'b1;
        repeat (c_HALF + 3) @(negedge clk);
        #1;
        check("glitch_busy_seen", seen_busy, 1);
        check("glitch_busy_clear", busy, 0);
        check("glitch_no_valid", q_even.size(), 0);

        // Back-to-back frames
        q_even.delete();
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        idle(4);
        check("b2b_count", q_even.size(), 2);
        if (q_even.size() >= 2) begin
            check("b2b_first", q_even[0], {2'b00, 8'h55});
            check("b2b_second", q_even[1], {2'b00, 8'hFF});
        end

        // Reset during data bit 4 of 0x3C
        q_even.delete();
        send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data_out", data_out, 0);
        check("mid_rst_valid", data_valid, 0);
        check("mid_rst_perr", parity_err, 0);
        check("mid_rst_ferr", frame_err, 0);
        check("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        check("mid_rst_no_valid", q_even.size(), 0);
        send_frame(8'h81, 1'b0, 1'b1);
        idle(4);
        check_one("81_after_rst", 8'h81, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_parity_rx
`default_nettype wire
